// File: rtl/cell_comm_rx_packet_check.sv
// Frames fixed 4-word FA packets from one Aurora RX stream, checks length/CRC/magic,
// strobes out good packets and keeps saturating per-class counters.
module cell_comm_rx_packet_check #(
    parameter logic [7:0] MAGIC         = 8'hA5,
    parameter int         COUNTER_WIDTH = 16
) (
    input  logic                     auroraUserClk,
    input  logic                     auroraUserReset,
    input  logic                     channelUp,
    input  logic                     axisRxTvalid,
    input  logic                     axisRxTlast,
    input  logic [31:0]              axisRxTdata,
    input  logic                     axisRxCRCvalid,
    input  logic                     axisRxCRCpass,
    output logic                     pktValid,
    output logic [7:0]               pktCellIndex,
    output logic [7:0]               pktBpmIndex,
    output logic [31:0]              pktX,
    output logic [31:0]              pktY,
    output logic [31:0]              pktSum,
    output logic [COUNTER_WIDTH-1:0] goodCount,
    output logic [COUNTER_WIDTH-1:0] lengthFaults,
    output logic [COUNTER_WIDTH-1:0] crcFaults,
    output logic [COUNTER_WIDTH-1:0] headerFaults
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BODY    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                   state_q;
    logic [1:0]               idx_q;
    logic [31:0]              hdr_q, x_q, y_q;
    logic                     pkt_valid_q;
    logic [7:0]               pkt_cell_q, pkt_bpm_q;
    logic [31:0]              pkt_x_q, pkt_y_q, pkt_sum_q;
    logic [COUNTER_WIDTH-1:0] good_q, len_q, crc_q, hdr_cnt_q;
    logic [COUNTER_WIDTH-1:0] good_d, len_d, crc_d, hdr_cnt_d;

    logic beat, len_evt, crc_evt, hdr_evt, good_evt, eval, crc_bad;

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(
        input logic [COUNTER_WIDTH-1:0] v,
        input logic                     en
    );
        return (en && (v != '1)) ? v + COUNTER_WIDTH'(1) : v;
    endfunction

    // Beats only count while the channel is up; a dropped channel aborts silently.
    always_comb begin
        beat     = channelUp && axisRxTvalid;
        len_evt  = 1'b0;
        eval     = 1'b0;
        crc_bad  = !(axisRxCRCvalid && axisRxCRCpass);
        unique case (state_q)
            IDLE: len_evt = beat && axisRxTlast;
            BODY: begin
                if (idx_q != 2'd3) begin
                    len_evt = beat && axisRxTlast;
                end else begin
                    len_evt = beat && !axisRxTlast;
                    eval    = beat && axisRxTlast;
                end
            end
            default: len_evt = 1'b0;
        endcase
        crc_evt  = eval && crc_bad;
        hdr_evt  = eval && !crc_bad && (hdr_q[31:24] != MAGIC);
        good_evt = eval && !crc_bad && (hdr_q[31:24] == MAGIC);
    end

    assign good_d    = sat_inc(good_q, good_evt);
    assign len_d     = sat_inc(len_q, len_evt);
    assign crc_d     = sat_inc(crc_q, crc_evt);
    assign hdr_cnt_d = sat_inc(hdr_cnt_q, hdr_evt);

    always_ff @(posedge auroraUserClk) begin
        if (auroraUserReset) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            hdr_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pkt_valid_q <= 1'b0;
            pkt_cell_q  <= '0;
            pkt_bpm_q   <= '0;
            pkt_x_q     <= '0;
            pkt_y_q     <= '0;
            pkt_sum_q   <= '0;
            good_q      <= '0;
            len_q       <= '0;
            crc_q       <= '0;
            hdr_cnt_q   <= '0;
        end else begin
            pkt_valid_q <= good_evt;
            good_q      <= good_d;
            len_q       <= len_d;
            crc_q       <= crc_d;
            hdr_cnt_q   <= hdr_cnt_d;
            if (good_evt) begin
                pkt_cell_q <= hdr_q[23:16];
                pkt_bpm_q  <= hdr_q[15:8];
                pkt_x_q    <= x_q;
                pkt_y_q    <= y_q;
                pkt_sum_q  <= axisRxTdata;
            end
            if (!channelUp) begin
                state_q <= IDLE;
                idx_q   <= 2'd0;
            end else if (axisRxTvalid) begin
                unique case (state_q)
                    IDLE: begin
                        hdr_q <= axisRxTdata;
                        if (!axisRxTlast) begin
                            state_q <= BODY;
                            idx_q   <= 2'd1;
                        end
                    end
                    BODY: begin
                        if (idx_q == 2'd1) x_q <= axisRxTdata;
                        if (idx_q == 2'd2) y_q <= axisRxTdata;
                        if (axisRxTlast) begin
                            state_q <= IDLE;
                            idx_q   <= 2'd0;
                        end else if (idx_q == 2'd3) begin
                            // Overlong frame: drop the rest until its tlast.
                            state_q <= DISCARD;
                            idx_q   <= 2'd0;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                    DISCARD: begin
                        if (axisRxTlast) state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        idx_q   <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign pktValid     = pkt_valid_q;
    assign pktCellIndex = pkt_cell_q;
    assign pktBpmIndex  = pkt_bpm_q;
    assign pktX         = pkt_x_q;
    assign pktY         = pkt_y_q;
    assign pktSum       = pkt_sum_q;
    assign goodCount    = good_q;
    assign lengthFaults = len_q;
    assign crcFaults    = crc_q;
    assign headerFaults = hdr_cnt_q;

endmodule

// File: tb/tb_cell_comm_rx_packet_check.sv
// Bench for cell_comm_rx_packet_check: directed table, corner sequences and a
// frame-level reference model checked every cycle against 16-bit and 2-bit counter builds.
module tb_cell_comm_rx_packet_check;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, chup, tv, tl, cv, cp;
    logic [31:0] td;

    logic        a_vld, b_vld;
    logic [7:0]  a_cell, a_bpm, b_cell, b_bpm;
    logic [31:0] a_x, a_y, a_sum, b_x, b_y, b_sum;
    logic [15:0] a_good, a_len, a_crc, a_hdr;
    logic [1:0]  b_good, b_len, b_crc, b_hdr;

    cell_comm_rx_packet_check #(.MAGIC(8'hA5), .COUNTER_WIDTH(16)) dut16 (
        .auroraUserClk(clk), .auroraUserReset(rst), .channelUp(chup),
        .axisRxTvalid(tv), .axisRxTlast(tl), .axisRxTdata(td),
        .axisRxCRCvalid(cv), .axisRxCRCpass(cp),
        .pktValid(a_vld), .pktCellIndex(a_cell), .pktBpmIndex(a_bpm),
        .pktX(a_x), .pktY(a_y), .pktSum(a_sum),
        .goodCount(a_good), .lengthFaults(a_len), .crcFaults(a_crc), .headerFaults(a_hdr));

    cell_comm_rx_packet_check #(.MAGIC(8'hA5), .COUNTER_WIDTH(2)) dut2 (
        .auroraUserClk(clk), .auroraUserReset(rst), .channelUp(chup),
        .axisRxTvalid(tv), .axisRxTlast(tl), .axisRxTdata(td),
        .axisRxCRCvalid(cv), .axisRxCRCpass(cp),
        .pktValid(b_vld), .pktCellIndex(b_cell), .pktBpmIndex(b_bpm),
        .pktX(b_x), .pktY(b_y), .pktSum(b_sum),
        .goodCount(b_good), .lengthFaults(b_len), .crcFaults(b_crc), .headerFaults(b_hdr));

    int npass = 0, ntotal = 0, cyc = 0;
    int strobes[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // Reference model: collects beats of the current frame and classifies it.
    int          m_len, m_good, m_lenf, m_crcf, m_hdrf;
    bit          m_disc, m_vld;
    logic [31:0] m_beats[4];
    logic [7:0]  m_cell, m_bpm;
    logic [31:0] m_x, m_y, m_sum;

    function automatic logic [15:0] s16(input int c);
        return (c > 65535) ? 16'hFFFF : 16'(c);
    endfunction
    function automatic logic [1:0] s2(input int c);
        return (c > 3) ? 2'd3 : 2'(c);
    endfunction

    task automatic model_reset();
        m_len = 0; m_disc = 0; m_vld = 0;
        m_good = 0; m_lenf = 0; m_crcf = 0; m_hdrf = 0;
        m_cell = 0; m_bpm = 0; m_x = 0; m_y = 0; m_sum = 0;
    endtask

    task automatic model_edge();
        m_vld = 0;
        if (rst) begin
            model_reset();
        end else if (!chup) begin
            m_len = 0; m_disc = 0;
        end else if (tv) begin
            if (m_disc) begin
                if (tl) m_disc = 0;
            end else begin
                if (m_len < 4) m_beats[m_len] = td;
                m_len++;
                if (tl) begin
                    if (m_len < 4) m_lenf++;
                    else if (!(cv && cp)) m_crcf++;
                    else if (m_beats[0][31:24] != 8'hA5) m_hdrf++;
                    else begin
                        m_good++; m_vld = 1;
                        m_cell = m_beats[0][23:16]; m_bpm = m_beats[0][15:8];
                        m_x = m_beats[1]; m_y = m_beats[2]; m_sum = m_beats[3];
                    end
                    m_len = 0;
                end else if (m_len == 4) begin
                    m_lenf++; m_disc = 1; m_len = 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic up, input logic v, input logic l,
                        input logic [31:0] d, input logic crv, input logic crp);
        rst = r; chup = up; tv = v; tl = l; td = d; cv = crv; cp = crp;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        if (a_vld) strobes.push_back(cyc);
        chk("pktValid", {a_vld, b_vld}, {m_vld, m_vld});
        chk("pktFields", {a_cell, a_bpm, a_x, a_y, a_sum}, {m_cell, m_bpm, m_x, m_y, m_sum});
        chk("counters16", {a_good, a_len, a_crc, a_hdr},
            {s16(m_good), s16(m_lenf), s16(m_crcf), s16(m_hdrf)});
        chk("counters2", {b_good, b_len, b_crc, b_hdr},
            {s2(m_good), s2(m_lenf), s2(m_crcf), s2(m_hdrf)});
    endtask

    task automatic beat(input logic [31:0] d, input logic l, input logic crv, input logic crp);
        step(1'b0, 1'b1, 1'b1, l, d, crv, crp);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask
    task automatic pkt4(input logic [31:0] h, input logic crv, input logic crp);
        beat(h, 1'b0, 1'b0, 1'b0);
        beat(32'h11, 1'b0, 1'b0, 1'b0);
        beat(32'h22, 1'b0, 1'b0, 1'b0);
        beat(32'h33, 1'b1, crv, crp);
    endtask

    typedef struct {
        logic        v, l;
        logic [31:0] d;
        logic        cv, cp;
        logic        ev;
        int          eg, el, ec, eh;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic v, input logic l, input logic [31:0] d, input logic crv,
                       input logic crp, input logic ev, input int eg, input int el,
                       input int ec, input int eh);
        vec_t t;
        t.v = v; t.l = l; t.d = d; t.cv = crv; t.cp = crp;
        t.ev = ev; t.eg = eg; t.el = el; t.ec = ec; t.eh = eh;
        tbl.push_back(t);
    endtask

    initial begin
        int t0, lens[9];
        model_reset();
        rst = 1; chup = 1; tv = 0; tl = 0; td = 0; cv = 0; cp = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hA5FFFFFF, 1'b1, 1'b1);
        chk("reset_state", {a_vld, a_cell, a_bpm, a_x, a_y, a_sum, a_good, a_len, a_crc, a_hdr},
            128'h0);

        // Directed table: inputs and hand-derived outputs one cycle after each beat.
        add(1,0,32'hA5030700,0,0, 0,0,0,0,0); add(1,0,32'h11,0,0, 0,0,0,0,0);
        add(1,0,32'h22,0,0, 0,0,0,0,0);       add(1,1,32'h33,1,1, 1,1,0,0,0);
        add(0,0,32'h0,0,0, 0,1,0,0,0);
        add(1,0,32'hA5030700,0,0, 0,1,0,0,0); add(1,0,32'h11,0,0, 0,1,0,0,0);
        add(1,1,32'h22,1,1, 0,1,1,0,0);
        add(1,0,32'hA5030700,0,0, 0,1,1,0,0); add(1,0,32'h11,0,0, 0,1,1,0,0);
        add(1,0,32'h22,0,0, 0,1,1,0,0);       add(1,0,32'h33,1,1, 0,1,2,0,0);
        add(1,0,32'h44,0,0, 0,1,2,0,0);       add(1,1,32'h55,1,1, 0,1,2,0,0);
        add(1,0,32'hA5090B00,0,0, 0,1,2,0,0); add(1,0,32'h1111,0,0, 0,1,2,0,0);
        add(1,0,32'h2222,0,0, 0,1,2,0,0);     add(1,1,32'h3333,1,1, 1,2,2,0,0);
        add(1,0,32'h00030700,0,0, 0,2,2,0,0); add(1,0,32'h1,0,0, 0,2,2,0,0);
        add(1,0,32'h2,0,0, 0,2,2,0,0);        add(1,1,32'h3,1,0, 0,2,2,1,0);
        add(1,0,32'h5A030700,0,0, 0,2,2,1,0); add(1,0,32'h1,0,0, 0,2,2,1,0);
        add(1,0,32'h2,0,0, 0,2,2,1,0);        add(1,1,32'h3,1,1, 0,2,2,1,1);
        add(1,0,32'hA5030700,0,0, 0,2,2,1,1); add(1,0,32'h1,0,0, 0,2,2,1,1);
        add(1,0,32'h2,0,0, 0,2,2,1,1);        add(1,1,32'h3,0,1, 0,2,2,2,1);
        foreach (tbl[i]) begin
            step(1'b0, 1'b1, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].cv, tbl[i].cp);
            chk($sformatf("tbl%0d_vld", i), a_vld, tbl[i].ev);
            chk($sformatf("tbl%0d_cnt", i), {a_good, a_len, a_crc, a_hdr},
                {16'(tbl[i].eg), 16'(tbl[i].el), 16'(tbl[i].ec), 16'(tbl[i].eh)});
        end
        chk("tbl_fields", {a_cell, a_bpm, a_x, a_y, a_sum},
            {8'h09, 8'h0B, 32'h1111, 32'h2222, 32'h3333});

        // Gapped packet followed by two back-to-back packets.
        idle(2);
        strobes.delete();
        beat(32'hA5010200, 1'b0, 1'b0, 1'b0); idle(1);
        beat(32'h11, 1'b0, 1'b0, 1'b0);       idle(3);
        beat(32'h22, 1'b0, 1'b0, 1'b0);
        beat(32'h33, 1'b1, 1'b1, 1'b1);       idle(2);
        pkt4(32'hA5040500, 1'b1, 1'b1);
        pkt4(32'hA5060700, 1'b1, 1'b1);
        idle(1);
        chk("gap_strobe_count", 32'(strobes.size()), 32'd3);
        if (strobes.size() == 3) chk("b2b_spacing", 32'(strobes[2] - strobes[1]), 32'd4);
        chk("b2b_fields", {a_cell, a_bpm, a_sum}, {8'h06, 8'h07, 32'h33});

        // Channel drop after two beats discards the partial frame silently.
        t0 = a_good;
        beat(32'hA5010100, 1'b0, 1'b0, 1'b0);
        beat(32'h11, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h22, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h33, 1'b1, 1'b1);
        pkt4(32'hA5080900, 1'b1, 1'b1);
        idle(1);
        chk("chdrop_counts", {a_good, a_len, a_crc, a_hdr}, {16'(t0 + 1), 16'd2, 16'd2, 16'd1});
        chk("chdrop_fields", {a_cell, a_bpm}, {8'h08, 8'h09});

        // Saturation on the 2-bit build, then a one-cycle reset.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) pkt4(32'hA5000000, 1'b1, 1'b0);
        chk("sat_crc2", b_crc, 2'd3);
        chk("sat_crc16", a_crc, 16'd5);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_reset", {a_vld, b_vld, a_good, a_len, a_crc, a_hdr, b_good, b_len, b_crc, b_hdr},
            '0);

        // Random frames against the reference model.
        lens = '{1, 2, 3, 4, 4, 4, 4, 5, 6};
        for (int f = 0; f < 300; f++) begin
            int n;
            logic [31:0] h;
            n = lens[$urandom_range(0, 8)];
            h = $urandom;
            if ($urandom_range(0, 4) != 0) h[31:24] = 8'hA5;
            for (int b = 0; b < n; b++) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++)
                    step($urandom_range(0, 199) == 0, $urandom_range(0, 29) != 0, 1'b0,
                         1'($urandom), $urandom, 1'($urandom), 1'($urandom));
                step(1'b0, $urandom_range(0, 49) != 0, 1'b1, b == n - 1,
                     (b == 0) ? h : $urandom,
                     $urandom_range(0, 9) != 0, $urandom_range(0, 6) != 0);
            end
        end
        idle(2);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/cell_comm_rx_packet_check.md
Name: cell_comm_rx_packet_check

Overview:
Consumes the received AXI-stream of one cell-communication Aurora link (CCW or CW) in the link's user-clock domain. Frames fixed 4-word FA packets and checks length, header magic and the Aurora CRC flags. Presents each good packet's fields as a one-cycle strobe for the downstream FA merge logic, and counts each class of fault. One instance is used per link direction.

Parameters:
MAGIC, 8'hA5, required value of header word bits [31:24]
COUNTER_WIDTH, 16, width of each saturating fault/good counter

Ports:
auroraUserClk  in  1  link user clock; the only clock
auroraUserReset  in  1  synchronous, active-high reset
channelUp  in  1  Aurora channel-up status
axisRxTvalid  in  1  RX beat valid (no backpressure)
axisRxTlast  in  1  last beat of frame
axisRxTdata  in  32  RX data
axisRxCRCvalid  in  1  CRC result valid (accompanies the tlast beat)
axisRxCRCpass  in  1  CRC result
pktValid  out  1  one-cycle strobe: good packet fields valid
pktCellIndex  out  8  header [23:16]
pktBpmIndex  out  8  header [15:8]
pktX  out  32  word 1
pktY  out  32  word 2
pktSum  out  32  word 3
goodCount  out  COUNTER_WIDTH  good packets
lengthFaults  out  COUNTER_WIDTH  short or long frames
crcFaults  out  COUNTER_WIDTH  CRC failures
headerFaults  out  COUNTER_WIDTH  bad magic

Behaviour:
- Reset: all outputs are 0, state is IDLE, beat index is 0, and the holding registers are 0.
- The block never stalls. A beat is consumed only when axisRxTvalid=1.
- States and transitions:
  - IDLE: the next beat is header word 0 and is latched. If tlast=1 on that beat, count a length fault and stay in IDLE. Otherwise go to BODY with index=1.
  - BODY: beats 1..3 are latched into X, Y and Sum.
    - tlast on a beat with index<3: count a length fault, go to IDLE.
    - Index 3 with tlast=1: evaluate the packet (see below), go to IDLE.
    - Index 3 with tlast=0: count a length fault, go to DISCARD.
  - DISCARD: drop beats until a beat with tlast=1, then go to IDLE. Nothing further is counted for that frame.
- Evaluation on the index-3 tlast beat. At most one fault is counted per frame, with priority length > crc > header:
  - axisRxCRCvalid=0, or axisRxCRCvalid=1 with axisRxCRCpass=0: crcFaults++.
  - Otherwise, header[31:24]!=MAGIC: headerFaults++.
  - Otherwise: good. pktValid=1 in the cycle after that beat (latency 1). The pkt* fields update in the same cycle and hold until the next good packet. goodCount++.
- A CRC-fail flag seen on an already length-faulted frame does not increment crcFaults.
- pktValid is high for exactly one cycle per good packet. Back-to-back good packets give strobes 4 cycles apart; there is no minimum gap.
- channelUp=0: go to IDLE immediately and discard any partial frame with no fault counted. Counters hold their values. Beats are ignored while channelUp=0.
- Counters saturate at 2^COUNTER_WIDTH-1; they do not wrap. They are cleared only by auroraUserReset.
- Reset asserted mid-frame: everything returns to reset values on the next edge. A frame in progress is lost and not counted.

Test Plan:
- Good packet: 4 beats A5_03_07_00, 0x11, 0x22, 0x33, with tlast and CRCvalid/pass on beat 4 -> pktValid for 1 cycle, one cycle after beat 4; CellIndex=3, BpmIndex=7, X=0x11, Y=0x22, Sum=0x33; goodCount=1.
- Short and long frames: a 3-beat frame with tlast on beat 3 -> lengthFaults=1, no pktValid. Then a 6-beat frame -> lengthFaults=2, the 2 extra beats are dropped, no pktValid. Then a good packet -> pktValid, goodCount=1.
- CRC and header priority:
  - Good-length frame with CRCvalid=1, pass=0 and MAGIC=0x00 -> crcFaults=1, headerFaults=0.
  - Same frame with CRC pass and header 0x5A... -> headerFaults=1.
  - Good-length frame with CRCvalid=0 -> crcFaults=2.
- Gapped stream: the 4 beats of a good packet separated by 0-3 idle cycles (tvalid=0), back-to-back with a second good packet -> two pktValid strobes, with the strobes 4 cycles apart when there are no gaps.
- channelUp drop after beat 2, then channelUp returns and a good packet is sent -> no fault counted, the single good packet is decoded.
- Saturation with COUNTER_WIDTH=2: 5 CRC-fail frames -> crcFaults=3. Then assert auroraUserReset for 1 cycle -> all counters 0 and pktValid 0.
